// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, funct codes,
// ALU-control and FSM enums, and the EX/MEM latch layout.
package ex_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MULT
  } alu_ctl_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // Contents of the EX/MEM latch; all-zero is a bubble.
  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] bt;
    logic        zero;
    logic [31:0] res;
    logic [31:0] wd;
    logic [4:0]  dst;
  } ex_mem_t;

  // Unknown funct codes fall back to ADD.
  function automatic alu_ctl_e alu_ctrl(input logic [1:0] op, input logic [5:0] funct);
    alu_ctl_e c;
    c = ALU_ADD;
    case (op)
      ALUOP_ADD: c = ALU_ADD;
      ALUOP_SUB: c = ALU_SUB;
      ALUOP_OR:  c = ALU_OR;
      default: begin
        case (funct)
          FUNCT_SUB:  c = ALU_SUB;
          FUNCT_AND:  c = ALU_AND;
          FUNCT_OR:   c = ALU_OR;
          FUNCT_SLT:  c = ALU_SLT;
          FUNCT_MULT: c = ALU_MULT;
          default:    c = ALU_ADD;
        endcase
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ex_stage_mult_iter.sv
// Iterative shift-add multiplier: one partial product per step, low 32 bits kept.
// product_o is the accumulator after the current step, so the final step's
// result can be latched on the same edge that performs it.
module mult_iter #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        step_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        done_o,
  output logic [31:0] product_o
);
  localparam int CNT_W = $clog2(MUL_CYCLES);

  logic [31:0]      acc_q, acc_d;
  logic [31:0]      mcand_q, mplier_q;
  logic [CNT_W-1:0] cnt_q;

  // Add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
  end

  assign product_o = acc_d;
  assign done_o    = (cnt_q == CNT_W'(MUL_CYCLES - 1));

  // Load operands on start, then shift one bit per step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      acc_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, branch adder, destination mux and EX/MEM latch.
// MULT parks the instruction in a capture register, stalls upstream while the
// iterative multiplier runs, then releases the product into EX/MEM.
module ex_stage
  import ex_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [1:0]  id_ex_wb,
  input  logic [2:0]  id_ex_m,
  input  logic [3:0]  id_ex_ex,
  input  logic [31:0] npc,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic [31:0] sign_ext,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  output logic        stall,
  output logic [1:0]  ex_mem_wb,
  output logic [2:0]  ex_mem_m,
  output logic [31:0] branch_target,
  output logic        zero,
  output logic [31:0] alu_result,
  output logic [31:0] write_data,
  output logic [4:0]  ex_mux
);
  state_e      state_q, state_d;
  ex_mem_t     out_q, out_d;
  ex_mem_t     cap_q, cap_d;
  ex_mem_t     cur;
  alu_ctl_e    ctl;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic        mul_start, mul_step, mul_done;
  logic [31:0] mul_prod;

  assign ctl  = alu_ctrl(id_ex_ex[2:1], sign_ext[5:0]);
  assign op_b = id_ex_ex[0] ? sign_ext : rdata2;

  // Combinational ALU; MULT yields 0 here since its result comes from mult_iter.
  always_comb begin
    alu_res = '0;
    case (ctl)
      ALU_ADD:  alu_res = rdata1 + op_b;
      ALU_SUB:  alu_res = rdata1 - op_b;
      ALU_AND:  alu_res = rdata1 & op_b;
      ALU_OR:   alu_res = rdata1 | op_b;
      ALU_SLT:  alu_res = {31'd0, $signed(rdata1) < $signed(op_b)};
      default:  alu_res = '0;
    endcase
  end

  // Assemble the EX/MEM contents of the instruction currently on the inputs.
  always_comb begin
    cur      = '0;
    cur.wb   = id_ex_wb;
    cur.m    = id_ex_m;
    cur.bt   = npc + (sign_ext << 2);
    cur.res  = alu_res;
    cur.zero = (alu_res == 32'd0);
    cur.wd   = rdata2;
    cur.dst  = id_ex_ex[3] ? rd : rt;
  end

  mult_iter #(.MUL_CYCLES(MUL_CYCLES)) u_mult (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start),
    .step_i    (mul_step),
    .a_i       (rdata1),
    .b_i       (op_b),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  assign mul_step = (state_q == ST_MUL);
  assign stall    = (state_q == ST_MUL);

  // Next-state and next EX/MEM contents; default is a bubble.
  always_comb begin
    state_d   = state_q;
    out_d     = '0;
    cap_d     = cap_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          if (ctl == ALU_MULT) begin
            mul_start = 1'b1;
            cap_d     = cur;
            state_d   = ST_MUL;
          end else begin
            out_d = cur;
          end
        end
      end
      default: begin
        if (mul_done) begin
          out_d      = cap_q;
          out_d.res  = mul_prod;
          out_d.zero = (mul_prod == 32'd0);
          state_d    = ST_IDLE;
        end
      end
    endcase
  end

  // State, capture and EX/MEM registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cap_q   <= cap_d;
    end
  end

  assign ex_mem_wb     = out_q.wb;
  assign ex_mem_m      = out_q.m;
  assign branch_target = out_q.bt;
  assign zero          = out_q.zero;
  assign alu_result    = out_q.res;
  assign write_data    = out_q.wd;
  assign ex_mux        = out_q.dst;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: an expected-output queue is filled as each
// instruction is driven and drained one entry per clock edge.
module tb_ex_stage;
  logic        clk, rst, valid;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_m;
  logic [3:0]  id_ex_ex;
  logic [31:0] npc, rdata1, rdata2, sign_ext;
  logic [4:0]  rt, rd;
  logic        stall;
  logic [1:0]  ex_mem_wb;
  logic [2:0]  ex_mem_m;
  logic [31:0] branch_target, alu_result, write_data;
  logic        zero;
  logic [4:0]  ex_mux;

  int total = 0;
  int bad   = 0;
  logic [106:0] exp_q[$];
  logic         stall_q[$];
  logic [106:0] pending;

  ex_stage #(.MUL_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .valid(valid), .id_ex_wb(id_ex_wb), .id_ex_m(id_ex_m),
    .id_ex_ex(id_ex_ex), .npc(npc), .rdata1(rdata1), .rdata2(rdata2),
    .sign_ext(sign_ext), .rt(rt), .rd(rd), .stall(stall), .ex_mem_wb(ex_mem_wb),
    .ex_mem_m(ex_mem_m), .branch_target(branch_target), .zero(zero),
    .alu_result(alu_result), .write_data(write_data), .ex_mux(ex_mux)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the EX/MEM contents for the current inputs.
  function automatic logic [106:0] model();
    logic [31:0] b, res, bt;
    logic [4:0]  dst;
    b   = id_ex_ex[0] ? sign_ext : rdata2;
    res = rdata1 + b;
    case (id_ex_ex[2:1])
      2'b01: res = rdata1 - b;
      2'b11: res = rdata1 | b;
      2'b10: begin
        case (sign_ext[5:0])
          6'b100010: res = rdata1 - b;
          6'b100100: res = rdata1 & b;
          6'b100101: res = rdata1 | b;
          6'b101010: res = ($signed(rdata1) < $signed(b)) ? 32'd1 : 32'd0;
          6'b011000: res = rdata1 * b;
          default:   res = rdata1 + b;
        endcase
      end
      default: res = rdata1 + b;
    endcase
    bt  = npc + {sign_ext[29:0], 2'b00};
    dst = id_ex_ex[3] ? rd : rt;
    return {id_ex_wb, id_ex_m, bt, (res == 32'd0), res, rdata2, dst};
  endfunction

  task automatic set_in(input logic v, input logic [1:0] wb, input logic [2:0] m,
                        input logic [3:0] ex, input logic [31:0] pc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] se,
                        input logic [4:0] t, input logic [4:0] d);
    valid = v; id_ex_wb = wb; id_ex_m = m; id_ex_ex = ex; npc = pc;
    rdata1 = a; rdata2 = b; sign_ext = se; rt = t; rd = d;
  endtask

  task automatic set_rand();
    set_in(1'($urandom_range(0, 1)), 2'($urandom), 3'($urandom), 4'($urandom), $urandom,
           $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom));
  endtask

  // One clock edge; pop and compare one expected entry.
  task automatic tick(input string tag);
    logic [106:0] obs, e;
    logic         es;
    @(posedge clk);
    #1;
    obs = {ex_mem_wb, ex_mem_m, branch_target, zero, alu_result, write_data, ex_mux};
    total++;
    if (exp_q.size() == 0 || stall_q.size() == 0) begin
      bad++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e  = exp_q.pop_front();
      es = stall_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s out obs=%h exp=%h", tag, obs, e);
      end
      total++;
      assert (stall === es) else begin
        bad++;
        $error("FAIL %s stall obs=%b exp=%b", tag, stall, es);
      end
    end
  endtask

  task automatic expect_push(input logic [106:0] e, input logic s);
    exp_q.push_back(e);
    stall_q.push_back(s);
  endtask

  task automatic issue(input string tag);
    expect_push(valid ? model() : 107'd0, 1'b0);
    tick(tag);
  endtask

  // Accept edge E0 of a MULT currently on the inputs.
  task automatic mult_accept(input string tag);
    pending = model();
    expect_push(107'd0, 1'b1);
    tick(tag);
  endtask

  // Edges E1..E31 are bubbles with stall high; E32 delivers the product.
  task automatic mult_wait(input string tag);
    for (int i = 1; i < 32; i++) begin
      expect_push(107'd0, 1'b1);
      tick(tag);
    end
    expect_push(pending, 1'b0);
    tick(tag);
  endtask

  initial begin
    // Reset held for two cycles with random inputs.
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_rand();
      expect_push(107'd0, 1'b0);
      tick("reset");
    end
    rst = 1'b1;

    // First ADD after reset, then assorted ALU operations.
    set_in(1, 2'b10, 3'b000, 4'b1100, 32'h10, 32'd7, 32'd8, 32'h20, 5'd3, 5'd4);
    issue("add_first");
    set_in(1, 2'b10, 3'b000, 4'b1100, 32'h14, 32'd5, 32'd5, 32'h22, 5'd3, 5'd9);
    issue("sub_zero");
    set_in(1, 2'b10, 3'b000, 4'b1100, 32'h18, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd1, 5'd2);
    issue("slt");
    set_in(1, 2'b10, 3'b000, 4'b1100, 32'h1C, 32'hF0F0, 32'hFF00, 32'h24, 5'd6, 5'd7);
    issue("and");
    set_in(1, 2'b10, 3'b000, 4'b1100, 32'h20, 32'hF0F0, 32'h0F0F, 32'h25, 5'd6, 5'd8);
    issue("or");
    set_in(1, 2'b10, 3'b000, 4'b1100, 32'h20, 32'h1, 32'h2, 32'h3F, 5'd6, 5'd8);
    issue("funct_default");
    set_in(1, 2'b11, 3'b010, 4'b0001, 32'h24, 32'h100, 32'h55, 32'hFFFFFFFC, 5'd12, 5'd13);
    issue("lw");
    set_in(1, 2'b00, 3'b100, 4'b0010, 32'h40, 32'h9, 32'h9, 32'd3, 5'd2, 5'd0);
    issue("beq");
    set_in(1, 2'b10, 3'b000, 4'b0111, 32'h44, 32'h1200, 32'h0, 32'h0034, 5'd5, 5'd0);
    issue("ori");
    set_in(0, 2'b11, 3'b111, 4'b1100, 32'h48, 32'h3, 32'h4, 32'h20, 5'd5, 5'd6);
    issue("bubble");

    // MULT with a held ADD behind it.
    set_in(1, 2'b10, 3'b000, 4'b1100, 32'h50, 32'h12345, 32'h10, 32'h18, 5'd1, 5'd17);
    mult_accept("mult_accept");
    set_in(1, 2'b10, 3'b000, 4'b1100, 32'h54, 32'd100, 32'd23, 32'h20, 5'd2, 5'd18);
    mult_wait("mult_a");
    issue("held_add");

    // Back-to-back MULTs; the second waits on the inputs during the first.
    set_in(1, 2'b10, 3'b000, 4'b1100, 32'h60, 32'hFFFFFFFF, 32'd2, 32'h18, 5'd3, 5'd19);
    mult_accept("mult_b_accept");
    set_in(1, 2'b10, 3'b000, 4'b1100, 32'h64, $urandom, $urandom, 32'h18, 5'd4, 5'd20);
    mult_wait("mult_b");
    mult_accept("mult_c_accept");
    set_in(0, 2'b11, 3'b111, 4'b1100, 32'h68, 32'd1, 32'd1, 32'h20, 5'd4, 5'd21);
    mult_wait("mult_c");
    issue("post_mult_bubble");

    // Reset while the counter reads 10: the product must never appear.
    set_in(1, 2'b10, 3'b000, 4'b1100, 32'h70, 32'd1234, 32'd5678, 32'h18, 5'd5, 5'd22);
    mult_accept("abort_accept");
    for (int i = 1; i <= 10; i++) begin
      expect_push(107'd0, 1'b1);
      tick("abort_run");
    end
    rst = 1'b0;
    expect_push(107'd0, 1'b0);
    tick("abort_reset");
    rst = 1'b1;
    valid = 1'b0;
    for (int i = 0; i < 34; i++) begin
      expect_push(107'd0, 1'b0);
      tick("abort_quiet");
    end

    // A random stream of non-MULT instructions.
    for (int i = 0; i < 20; i++) begin
      set_rand();
      if (id_ex_ex[2:1] == 2'b10 && sign_ext[5:0] == 6'b011000) sign_ext[5:0] = 6'b100000;
      issue("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline. Sits between the ID/EX register and the memory stage. It computes the ALU result, the zero flag and the branch target. It selects the destination register and registers everything into the EX/MEM pipeline latch that the memory stage consumes. R-type MULT runs on an iterative 32-cycle shift-add unit, and the stage stalls upstream while that unit is busy.

## Interface
Parameters:
- `MUL_CYCLES`, 32: iterations of the shift-add multiplier. Fixed at 32 for a 32-bit datapath.

Ports:
- `clk`  in  1  pipeline clock; all state changes on posedge.
- `rst`  in  1  reset, synchronous, active-low: sampled on posedge, `rst==0` resets.
- `valid`  in  1  ID/EX holds a real instruction. 0 means bubble.
- `id_ex_wb`  in  2  {regWrite, memToReg}, passed through.
- `id_ex_m`  in  3  {branch, memRead, memWrite}, passed through.
- `id_ex_ex`  in  4  {regDst, aluOp[1:0], aluSrc}.
- `npc`  in  32  PC+4 of the instruction.
- `rdata1`, `rdata2`  in  32  register operands.
- `sign_ext`  in  32  sign-extended immediate; low 6 bits are funct.
- `rt`, `rd`  in  5  instruction fields [20:16], [15:11].
- `stall`  out  1  upstream must hold PC, IF/ID and ID/EX.
- `ex_mem_wb`  out  2  registered WB controls.
- `ex_mem_m`  out  3  registered {branch, memRead, memWrite}.
- `branch_target`  out  32  registered `npc + (sign_ext << 2)`.
- `zero`  out  1  registered, `alu_result == 0`.
- `alu_result`  out  32  registered ALU or multiply result (memory address for loads/stores).
- `write_data`  out  32  registered `rdata2` (store data).
- `ex_mux`  out  5  registered destination: `rd` if regDst, else `rt`.

## Operation
- Operand B = aluSrc ? `sign_ext` : `rdata2`.
- ALU control:
  - aluOp 00 → ADD.
  - aluOp 01 → SUB.
  - aluOp 10 → decode funct:
    - 100000 → ADD
    - 100010 → SUB
    - 100100 → AND
    - 100101 → OR
    - 101010 → SLT (signed, result 0/1)
    - 011000 → MULT
    - any other funct → ADD.
  - aluOp 11 → OR (ori).
- All arithmetic is 32-bit with wrap-around. Overflow is ignored, with no exception.
- MULT result is the low 32 bits of the product. An unsigned shift-add is used; the low word is identical for signed operands.
- FSM states:
  - IDLE:
    - `valid` and not MULT: load EX/MEM from the combinational result.
    - `valid` and MULT: capture A, B and all pass-through fields; load a bubble into EX/MEM; clear the counter; go to MUL.
    - `!valid`: load a bubble into EX/MEM.
  - MUL:
    - One iteration per cycle.
    - If counter != 31: counter+1, EX/MEM loads a bubble.
    - If counter == 31: EX/MEM loads the product and the captured fields; go to IDLE.
- Bubble: `ex_mem_wb = 0` and `ex_mem_m = 0`. Data fields are don't-care but driven to 0.
- `stall` = (state == MUL), combinational from state.
- While `stall` is high the stage ignores its ID/EX inputs. Upstream holds the following instruction on the inputs until `stall` drops.
- Forwarding and hazard detection are out of scope.

## Timing
- Reset (`rst==0` at posedge): state IDLE, counter 0, every registered output 0, `stall` 0. This includes reset mid-multiply, which abandons the operation and produces no result.
- Non-MULT latency: 1 cycle. Inputs valid in cycle N appear on EX/MEM outputs after edge N.
- MULT:
  - Accept edge E0: state goes to MUL.
  - Edges E1..E31: bubble into EX/MEM.
  - Edge E32: product enters EX/MEM.
  - `stall` is high for exactly 32 cycles, starting the cycle after E0.
- The instruction waiting behind a MULT is processed in the first IDLE cycle after E32, which issues back-to-back with the product.
- MULT followed by MULT: the second MULT is accepted in that first IDLE cycle, with no extra gap.
- `valid=0` while in MUL has no effect.

## Structure
- Shared package `ex_pkg` holds:
  - aluOp codes;
  - funct constants;
  - ALU-control enum: ADD, SUB, AND, OR, SLT, MULT;
  - FSM state enum: IDLE, MUL.
- Sub-module `mult_iter`: shift-add multiplier with start, operands, counter, `done` and product outputs. It holds the accumulator and the shifted multiplicand and multiplier registers.
- The ALU, ALU control, destination mux, branch adder and EX/MEM register sit in `ex_stage`.

## Test plan
- Reset: hold `rst=0` for 2 cycles with random inputs → all outputs 0, `stall` 0. Release → the first valid ADD result appears one edge later.
- R-type SUB:
  - `rdata1=5`, `rdata2=5`, aluOp 10, funct 100010, regDst 1, `rd=9` → `alu_result=0`, `zero=1`, `ex_mux=9`.
  - SLT with `rdata1=-1`, `rdata2=1` → 1.
- lw/beq:
  - aluSrc 1, `sign_ext=-4`, `rdata1=0x100` → `alu_result=0xFC`, `ex_mux=rt`, `ex_mem_m=010`.
  - beq with `npc=0x40`, `sign_ext=3` → `branch_target=0x4C`.
- MULT:
  - `rdata1=0x12345`, `rdata2=0x10` → `stall` high exactly 32 cycles, 32 bubbles, then `alu_result=0x123450` with the captured `ex_mux`.
  - `0xFFFFFFFF * 2` → `0xFFFFFFFE`.
- MULT, then an ADD held on the inputs → the ADD result appears exactly one cycle after the product, and no instruction is lost or duplicated.
- Reset asserted at MUL counter 10 → next cycle IDLE, `stall` 0, outputs 0; the aborted product never appears.
